// File: rtl/msk_mixcol32_pkg.sv
// Shared definitions for the masked MixColumns column stage: GF constant,
// share/bit layout helper and column-mode encoding.
package msk_mixcol32_pkg;

  localparam int unsigned ROWS = 4;
  localparam logic [7:0] GF_POLY = 8'h1B;

  typedef enum logic [1:0] {
    MODE_MC     = 2'd0,
    MODE_IMC    = 2'd1,
    MODE_BYPASS = 2'd2
  } mode_e;

  // Bit i of share j within a masked byte sits at i*d+j.
  function automatic int unsigned share_idx(input int unsigned bit_i,
                                            input int unsigned share,
                                            input int unsigned d);
    return bit_i * d + share;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
  endfunction

  function automatic mode_e mode_sel(input logic inv, input logic bypass);
    if (bypass) return MODE_BYPASS;
    if (inv) return MODE_IMC;
    return MODE_MC;
  endfunction

endpackage

// File: rtl/msk_gf_cmul8.sv
// Share-wise GF(2^8) constant multiples of one masked byte; each share is
// processed on its own so no share ever mixes with another.
module msk_gf_cmul8
  import msk_mixcol32_pkg::*;
#(
  parameter int unsigned D = 2
) (
  input  logic [8*D-1:0] a,
  output logic [8*D-1:0] x2,
  output logic [8*D-1:0] x3,
  output logic [8*D-1:0] x9,
  output logic [8*D-1:0] xb,
  output logic [8*D-1:0] xd,
  output logic [8*D-1:0] xe
);

  for (genvar j = 0; j < D; j++) begin : g_share
    logic [7:0] s;
    logic [7:0] m2;
    logic [7:0] m4;
    logic [7:0] m8;

    for (genvar i = 0; i < 8; i++) begin : g_unpack
      assign s[i] = a[share_idx(i, j, D)];
    end

    assign m2 = xtime(s);
    assign m4 = xtime(m2);
    assign m8 = xtime(m4);

    for (genvar i = 0; i < 8; i++) begin : g_pack
      assign x2[share_idx(i, j, D)] = m2[i];
      assign x3[share_idx(i, j, D)] = m2[i] ^ s[i];
      assign x9[share_idx(i, j, D)] = m8[i] ^ s[i];
      assign xb[share_idx(i, j, D)] = m8[i] ^ m2[i] ^ s[i];
      assign xd[share_idx(i, j, D)] = m8[i] ^ m4[i] ^ s[i];
      assign xe[share_idx(i, j, D)] = m8[i] ^ m4[i] ^ m2[i];
    end
  end

endmodule

// File: rtl/msk_mixcol32.sv
// Masked AES column stage: MixColumns / InvMixColumns / bypass on one masked
// column per transfer, one registered stage with a column-index tag.
module msk_mixcol32
  import msk_mixcol32_pkg::*;
#(
  parameter int unsigned D = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [32*D-1:0] in_col,
  input  logic            in_inv,
  input  logic            in_bypass,
  input  logic            in_clear,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [32*D-1:0] out_col,
  output logic [1:0]      out_idx,
  output logic            out_last
);

  localparam int unsigned BYTE_W = 8 * D;
  localparam int unsigned COL_W  = 32 * D;

  logic [BYTE_W-1:0] a   [ROWS];
  logic [BYTE_W-1:0] x2  [ROWS];
  logic [BYTE_W-1:0] x3  [ROWS];
  logic [BYTE_W-1:0] x9  [ROWS];
  logic [BYTE_W-1:0] xb  [ROWS];
  logic [BYTE_W-1:0] xd  [ROWS];
  logic [BYTE_W-1:0] xe  [ROWS];
  logic [BYTE_W-1:0] mc  [ROWS];
  logic [BYTE_W-1:0] imc [ROWS];
  logic [COL_W-1:0]  res;
  logic [1:0]        cnt;
  logic [1:0]        idx_next;
  logic              accept;
  mode_e             mode;

  for (genvar k = 0; k < ROWS; k++) begin : g_row
    assign a[k] = in_col[k*BYTE_W +: BYTE_W];
    msk_gf_cmul8 #(.D(D)) u_cmul (
      .a  (a[k]),
      .x2 (x2[k]),
      .x3 (x3[k]),
      .x9 (x9[k]),
      .xb (xb[k]),
      .xd (xd[k]),
      .xe (xe[k])
    );
  end

  // Plain XOR of sharings keeps every share independent (layout is shared).
  always_comb begin
    mc[0]  = x2[0] ^ x3[1] ^ a[2]  ^ a[3];
    mc[1]  = a[0]  ^ x2[1] ^ x3[2] ^ a[3];
    mc[2]  = a[0]  ^ a[1]  ^ x2[2] ^ x3[3];
    mc[3]  = x3[0] ^ a[1]  ^ a[2]  ^ x2[3];
    imc[0] = xe[0] ^ xb[1] ^ xd[2] ^ x9[3];
    imc[1] = x9[0] ^ xe[1] ^ xb[2] ^ xd[3];
    imc[2] = xd[0] ^ x9[1] ^ xe[2] ^ xb[3];
    imc[3] = xb[0] ^ xd[1] ^ x9[2] ^ xe[3];
    mode   = mode_sel(in_inv, in_bypass);
    res    = in_col;
    case (mode)
      MODE_MC:  res = {mc[3], mc[2], mc[1], mc[0]};
      MODE_IMC: res = {imc[3], imc[2], imc[1], imc[0]};
      default:  res = in_col;
    endcase
  end

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign idx_next = in_clear ? 2'd0 : cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_col   <= '0;
      out_idx   <= 2'd0;
      out_last  <= 1'b0;
      cnt       <= 2'd0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_col   <= res;
      out_idx   <= idx_next;
      out_last  <= (idx_next == 2'd3);
      cnt       <= in_clear ? 2'd1 : cnt + 2'd1;
    end else begin
      if (in_clear) cnt <= 2'd0;
      if (out_ready) out_valid <= 1'b0;
    end
  end

endmodule
